// File: rtl/mux4_sel_pkg.sv
// Shared types and the round-robin pick function for the Mux4x1 select controller.
package mux4_sel_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, GRANT} state_t;

    typedef logic [1:0] ch_t;

    localparam int CNT_W = 4;

    // First set request scanning ptr, ptr+1, ... with natural 2-bit wrap.
    function automatic ch_t rr_pick(input logic [3:0] req, input ch_t ptr);
        ch_t  pick;
        ch_t  idx;
        logic found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + ch_t'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux4_rr_pick.sv
// Combinational rotate-priority encoder: request vector plus pointer to winning channel.
module mux4_rr_pick
    import mux4_sel_pkg::*;
(
    input  logic [3:0] req,
    input  ch_t        ptr,
    output ch_t        ch,
    output logic       hit
);

    assign ch  = rr_pick(req, ptr);
    assign hit = |req;

endmodule

// File: rtl/mux4_rr_sel_ctrl.sv
// Round-robin select controller and sample stream for the 4:1 mux.
// Optional MUX_SEL_LOCK_EN adds a lock input that holds the grant past DWELL samples.
module mux4_rr_sel_ctrl
    import mux4_sel_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       mux_y,
    output logic       s0,
    output logic       s1,
    output logic [3:0] gnt,
    output logic       dout,
    output logic [1:0] dout_ch,
    output logic       dout_valid,
    input  logic       dout_ready
`ifdef MUX_SEL_LOCK_EN
    ,
    input  logic       lock
`endif
);

    localparam logic [CNT_W-1:0] DWELL_C = CNT_W'(DWELL);

    state_t           state, state_nxt;
    ch_t              ch, ptr, pick_ch;
    logic             pick_hit;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic             fire, dwell_done, grant_exit, lock_hold;

`ifdef MUX_SEL_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    mux4_rr_pick u_pick (
        .req (req),
        .ptr (ptr),
        .ch  (pick_ch),
        .hit (pick_hit)
    );

    // Selects come straight from the registered channel, so they hold through IDLE.
    assign s0 = ch[1];
    assign s1 = ch[0];

    assign cnt_inc    = cnt + CNT_W'(1);
    assign fire       = (state == GRANT) && req[ch] && (!dout_valid || dout_ready);
    assign dwell_done = fire && (cnt_inc >= DWELL_C) && !lock_hold;
    assign grant_exit = (state == GRANT) && (!req[ch] || dwell_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_hit) state_nxt = SETTLE;
            SETTLE:  state_nxt = GRANT;
            GRANT:   if (grant_exit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant bookkeeping, dwell counter and the output holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch         <= '0;
            ptr        <= '0;
            cnt        <= '0;
            gnt        <= '0;
            dout       <= 1'b0;
            dout_ch    <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (state == IDLE && pick_hit) begin
                ch  <= pick_ch;
                gnt <= 4'b0001 << pick_ch;
                cnt <= '0;
            end
            if (fire) begin
                dout       <= mux_y;
                dout_ch    <= ch;
                dout_valid <= 1'b1;
                if (cnt < DWELL_C) cnt <= cnt_inc;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
            if (grant_exit) begin
                gnt <= '0;
                ptr <= ch + ch_t'(1);
            end
        end
    end

endmodule
